// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM period / high-time decoder.
package pwm_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT   = 8;
    localparam int CNT_MAX_DEFAULT = (1 << CNT_W_DEFAULT) - 1;

endpackage

// File: rtl/pwm_edge_sync.sv
// Samples pwm_in and produces single-cycle rise/fall strobes.
// PWM_DEC_SYNC_EN selects a two-flop synchronizer instead of a single sampling flop.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic s_cur;
    logic s_prev;

`ifdef PWM_DEC_SYNC_EN
    logic s_meta;

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s_cur  <= 1'b0;
        end else begin
            s_meta <= pwm_in;
            s_cur  <= s_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_cur <= 1'b0;
        else        s_cur <= pwm_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_prev <= 1'b0;
        else        s_prev <= s_cur;
    end

    assign rise = s_cur & ~s_prev;
    assign fall = ~s_cur & s_prev;

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and high time of pwm_in in enable ticks; flags loss of signal.
// Build option PWM_DEC_SYNC_EN adds a two-flop input synchronizer (one extra clk latency).
module pwm_decoder
    import pwm_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic rise;
    logic fall;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_reg, high_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             valid_nxt, timeout_nxt, locked_nxt;
    logic [CNT_W-1:0] cnt_step;
    logic [CNT_W-1:0] cnt_start;
    logic             saturate;

    assign cnt_step  = cnt + CNT_W'(enable);
    assign cnt_start = CNT_W'(enable);
    // Edges are checked before this in every state, so an edge wins over timeout.
    assign saturate  = enable && (cnt == CNT_MAX);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        high_nxt      = high_reg;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = 1'b0;
        locked_nxt    = locked;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = HIGH;
                    cnt_nxt   = cnt_start;
                end
            end
            HIGH: begin
                cnt_nxt = cnt_step;
                if (fall) begin
                    state_nxt = LOW;
                    high_nxt  = cnt;
                end else if (saturate) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    locked_nxt  = 1'b0;
                end
            end
            LOW: begin
                cnt_nxt = cnt_step;
                if (rise) begin
                    state_nxt     = HIGH;
                    cnt_nxt       = cnt_start;
                    period_nxt    = cnt;
                    high_time_nxt = high_reg;
                    valid_nxt     = 1'b1;
                    locked_nxt    = 1'b1;
                end else if (saturate) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    locked_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            high_reg  <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            high_reg  <= high_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
            locked    <= locked_nxt;
        end
    end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side companion to the waveform generator's free-running 8-bit counter: samples an external PWM/square-wave input and measures its period and high time in enable-qualified clock ticks. Reports each complete period with a one-cycle valid pulse. Flags loss of signal (stuck input or period too long) with a timeout pulse. Sits between the board input pin and the display/readout logic, so a generated waveform can be looped back and checked.

## Interface
- CNT_W, 8: width of the measurement counter and of both result outputs.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  timebase tick; counting advances only on cycles with enable=1.
- pwm_in  in  1  measured signal; asynchronous when synchronizer compiled in.
- period  out  CNT_W  ticks from rising edge to next rising edge, last complete period.
- high_time  out  CNT_W  ticks from rising edge to falling edge, same period.
- valid  out  1  one-cycle pulse when period/high_time update.
- timeout  out  1  one-cycle pulse when the counter saturates.
- locked  out  1  level; high after first valid, cleared by timeout or reset.

## Operation
- Reset values: period=0, high_time=0, valid=0, timeout=0, locked=0, cnt=0, high_reg=0, FSM=IDLE, sampling flops=0.
- Sampled signal s_cur (synchronizer/sample output) and s_prev (s_cur delayed one clk); rise = s_cur & ~s_prev, fall = ~s_cur & s_prev. Edges are detected every clk, independent of enable.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: cnt held at 0; fall ignored (partial first period discarded); rise -> HIGH, cnt <= enable ? 1 : 0.
  - HIGH: if enable, cnt <= cnt+1; fall -> LOW, high_reg <= cnt (current value, before increment), cnt <= cnt + enable.
  - LOW: if enable, cnt <= cnt+1; rise -> HIGH, period <= cnt, high_time <= high_reg, valid <= 1, locked <= 1, cnt <= enable ? 1 : 0.
- With enable tied high and input high H clocks out of P: period=P, high_time=H exactly.
- Saturation: in HIGH or LOW, if cnt = 2^CNT_W−1, enable=1 and no edge this cycle -> timeout <= 1, locked <= 0, cnt <= 0, FSM -> IDLE; period/high_time keep last values. An edge in the same cycle takes priority over timeout.
- Rise in HIGH and fall in LOW cannot occur (edges alternate); no extra handling.
- Outputs are registered; no combinational path from pwm_in or enable to any output.

## Timing
- With synchronizer: pwm_in high sampled at edge k -> s_cur=1 after edge k+1 -> valid/period registered after edge k+2.
- Without synchronizer: s_cur=1 after edge k -> valid after edge k+1.
- valid and timeout are exactly one clk wide; never asserted together.
- Minimum measurable pulse: one clk high or low (after synchronizer); shorter pulses may be lost.
- First valid appears at the second detected rising edge after reset or timeout.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), regardless of FSM state.

## Configuration
- PWM_DEC_SYNC_EN defined: two-flop synchronizer in front of edge detector; pwm_in may be asynchronous; latency as above.
- Not defined: single sampling flop; pwm_in must be synchronous to clk; latency one clk less. Measured values are identical in both builds.

## Structure
- Package pwm_dec_pkg: FSM state typedef (IDLE, HIGH, LOW), default CNT_W constant, counter max constant.
- Sub-module pwm_edge_sync: synchronizer (macro-controlled), s_prev register, rise/fall outputs; reset active-low asynchronous. Top holds FSM, counter, and output registers.

## Test plan
- CNT_W=8, enable=1, pwm_in periodic H=3/P=8, starting mid-high -> first partial period ignored; every valid reports period=8, high_time=3; locked=1 after first valid.
- enable toggling 1/0 each clk, same H=3/P=8 waveform -> period=4, high_time in {1,2} per phase alignment; no valid lost.
- pwm_in rises once then stays high, enable=1 -> timeout pulse exactly 256 clk after the rise-detect cycle; locked=0; period/high_time unchanged; FSM IDLE.
- 1-clk-high pulses every 10 clk -> period=10, high_time=1.
- Assert rst_n low in HIGH state -> all outputs 0 immediately; after release, the next valid reports only the fresh full period.
- Build with and without PWM_DEC_SYNC_EN, same stimulus -> identical period/high_time values; valid one clk later with the macro defined.
